// File: rtl/mouse_pkg.sv
// mouse_pkg: register map, status bit positions and FSM encoding shared with mouse_display
package mouse_pkg;
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_X      = 2'd1;
    localparam logic [1:0] REG_Y      = 2'd2;
    localparam logic [1:0] REG_CNT    = 2'd3;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    typedef enum logic [1:0] {
        B0     = 2'd0,
        B1     = 2'd1,
        B2     = 2'd2,
        COMMIT = 2'd3
    } state_t;
endpackage

// File: rtl/mouse_axis_accum.sv
// mouse_axis_accum: next cursor coordinate for one axis, clamped to 0..max
module mouse_axis_accum (
    input  logic [7:0] current,
    input  logic [8:0] delta,
    input  logic       negate,
    input  logic       ovf,
    input  logic [7:0] max,
    output logic [7:0] next
);
    logic signed [10:0] cur_ext;
    logic signed [10:0] d_ext;
    logic signed [10:0] sum;

    // 11 bits hold every sum of an 8-bit position and a 9-bit signed delta
    always_comb begin
        cur_ext = signed'({3'b000, current});
        d_ext   = signed'({{2{delta[8]}}, delta});
        sum     = negate ? cur_ext - d_ext : cur_ext + d_ext;
        next    = ovf ? current :
                  (sum < 0) ? 8'd0 :
                  (sum > signed'({3'b000, max})) ? max : sum[7:0];
    end
endmodule

// File: rtl/mouse_regs.sv
// mouse_regs: assembles 3-byte PS/2 mouse packets into status/x/y/count registers
module mouse_regs
    import mouse_pkg::*;
#(
    parameter int          X_MAX   = 255,
    parameter int          Y_MAX   = 239,
    parameter logic [19:0] TIMEOUT = 20'd1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic [1:0] addr,
    output logic [7:0] data,
    output logic       pkt_done,
    output logic       sync_err
);
    localparam logic [7:0] XM = 8'(X_MAX);
    localparam logic [7:0] YM = 8'(Y_MAX);

    state_t      state;
    state_t      state_n;
    logic [19:0] timer;
    logic        expired;
    logic [7:0]  s_tmp;
    logic [7:0]  dx_tmp;
    logic [7:0]  dy_tmp;
    logic [7:0]  status;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  pkt_cnt;
    logic [7:0]  nx;
    logic [7:0]  ny;

    assign expired = (timer == TIMEOUT - 20'd1);

    mouse_axis_accum u_x (
        .current(x),
        .delta  ({s_tmp[XSIGN], dx_tmp}),
        .negate (1'b0),
        .ovf    (s_tmp[XOVF]),
        .max    (XM),
        .next   (nx)
    );

    // PS/2 +Y points up while screen +Y points down, so the y delta is subtracted
    mouse_axis_accum u_y (
        .current(y),
        .delta  ({s_tmp[YSIGN], dy_tmp}),
        .negate (1'b1),
        .ovf    (s_tmp[YOVF]),
        .max    (YM),
        .next   (ny)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= B0;
        else      state <= state_n;
    end

    // Next state: a byte always beats a coincident timeout expiry
    always_comb begin
        state_n = state;
        unique case (state)
            B0:      state_n = (rx_valid && rx_byte[SYNC]) ? B1 : B0;
            B1:      state_n = rx_valid ? B2 : expired ? B0 : B1;
            B2:      state_n = rx_valid ? COMMIT : expired ? B0 : B2;
            COMMIT:  state_n = B0;
            default: state_n = B0;
        endcase
    end

    // Inter-byte idle timer, only running while a packet is partially received
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   timer <= '0;
        else if (state == B0 || state == COMMIT)    timer <= '0;
        else if (rx_valid || expired)               timer <= '0;
        else                                        timer <= timer + 20'd1;
    end

    // Byte capture, commit of the assembled packet and event pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_tmp    <= '0;
            dx_tmp   <= '0;
            dy_tmp   <= '0;
            status   <= '0;
            x        <= '0;
            y        <= '0;
            pkt_cnt  <= '0;
            pkt_done <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            pkt_done <= (state == COMMIT);
            sync_err <= (state == B0) && rx_valid && !rx_byte[SYNC];
            if (state == B0 && rx_valid && rx_byte[SYNC]) s_tmp  <= rx_byte;
            if (state == B1 && rx_valid)                  dx_tmp <= rx_byte;
            if (state == B2 && rx_valid)                  dy_tmp <= rx_byte;
            if (state == COMMIT) begin
                status  <= s_tmp;
                x       <= nx;
                y       <= ny;
                pkt_cnt <= pkt_cnt + 8'd1;
            end
        end
    end

    // Zero-latency read port for mouse_display
    always_comb begin
        data = (addr == REG_STATUS) ? status :
               (addr == REG_X)      ? x :
               (addr == REG_Y)      ? y : pkt_cnt;
    end
endmodule
